// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The trailing checksum is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int LEN_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four accepted bytes, least-significant first, into one 32-bit word.
// word_valid and word are combinational and valid in the cycle the fourth byte is taken.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_WIDTH = $clog2(BYTES_PER_WORD);

  logic [CNT_WIDTH-1:0] byte_cnt;
  logic [23:0]          shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else if (take) begin
      byte_cnt  <= byte_cnt + 1'b1;
      shift_reg <= {byte_in, shift_reg[23:8]};
    end
  end

  assign word_valid = take && (byte_cnt == CNT_WIDTH'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, shift_reg};

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams a length-prefixed byte image into instruction memory and
// releases the core from reset once it is complete. Optional macro: LOADER_CHECKSUM_EN.
//
// state  | meaning
// LEN_LO | waiting for low byte of the word count
// LEN_HI | waiting for high byte of the word count
// DATA   | receiving image words, one write per four bytes
// CHECK  | waiting for the XOR checksum byte (checksum builds only)
// DONE   | image accepted, core released
// ERROR  | image rejected, core held in reset
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [31:0]           imem_wr_data,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [LEN_WIDTH:0] DEPTH = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FINAL_STATE = CHECK;
`else
  localparam state_t FINAL_STATE = DONE;
`endif

  state_t                state, next_state;
  logic [7:0]            len_lo;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  logic [LEN_WIDTH-1:0]  len_n;
  logic                  len_too_big;
  logic                  word_valid;
  logic [31:0]           word;

  assign accept      = byte_valid && byte_ready;
  assign len_n       = {byte_data, len_lo};
  assign len_too_big = {1'b0, len_n} > DEPTH;

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .take       (accept && (state == DATA)),
    .byte_in    (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;

  // Running XOR of every byte since reset; the checksum byte itself is compared before folding in.
  always_ff @(posedge clk) begin
    if (rst)         xor_acc <= '0;
    else if (accept) xor_acc <= xor_acc ^ byte_data;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      LEN_LO: if (accept) next_state = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_n == '0)      next_state = FINAL_STATE;
          else if (len_too_big) next_state = ERROR;
          else                  next_state = DATA;
        end
      end
      DATA: if (word_valid && (remaining == LEN_WIDTH'(1))) next_state = FINAL_STATE;
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (accept) next_state = (byte_data == xor_acc) ? DONE : ERROR;
`endif
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LEN_LO;
      len_lo       <= '0;
      remaining    <= '0;
      addr         <= '0;
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept && (state == LEN_LO)) len_lo    <= byte_data;
      if (accept && (state == LEN_HI)) remaining <= len_n;
      // Address cannot wrap into valid data: the length check caps N at the memory depth.
      if (word_valid) begin
        remaining    <= remaining - 1'b1;
        addr         <= addr + 1'b1;
        imem_wr_addr <= addr;
        imem_wr_data <= word;
      end
      imem_wr_en <= word_valid;
      byte_ready <= (next_state == LEN_LO) || (next_state == LEN_HI) ||
                    (next_state == DATA)   || (next_state == CHECK);
      load_done  <= (next_state == DONE);
      load_error <= (next_state == ERROR);
      cpu_rst_n  <= (state == DONE);
    end
  end

endmodule
